// File: rtl/instr_pkg.sv
// Shared constants and types for the instruction encoder and the decoder bench.
// Holds the group opcodes, the R-type function codes and the symbolic op encoding.
package instr_pkg;

    localparam logic [5:0] OP_GRP = 6'd9;
    localparam logic [5:0] OP_LW  = 6'd10;
    localparam logic [5:0] OP_SW  = 6'd11;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    typedef enum logic [2:0] {
        I_NOP = 3'd0,
        I_ADD = 3'd1,
        I_SUB = 3'd2,
        I_AND = 3'd3,
        I_OR  = 3'd4,
        I_MUL = 3'd5,
        I_LW  = 3'd6,
        I_SW  = 3'd7
    } op_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic op and fields to the 32-bit decoder word.
// Also used standalone by the decoder bench for round-trip checks.
module instr_field_pack
    import instr_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    logic [5:0] funct;

    always_comb begin
        funct = '0;
        case (op)
            I_ADD:   funct = FN_ADD;
            I_SUB:   funct = FN_SUB;
            I_AND:   funct = FN_AND;
            I_OR:    funct = FN_OR;
            I_MUL:   funct = FN_MUL;
            default: funct = '0;
        endcase

        word = '0;
        case (op)
            I_ADD, I_SUB, I_AND, I_OR, I_MUL: word = {OP_GRP, rs, rt, rd, 5'd0, funct};
            I_LW:    word = {OP_LW, rs, rt, imm};
            I_SW:    word = {OP_SW, rs, rt, imm};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts symbolic instructions over valid/ready and writes packed words to
// instruction memory from address 0, reporting count, completion and overflow.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              accept;
    logic              at_top;

    instr_field_pack u_pack (
        .op   (op_e'(op)),
        .rs   (rs),
        .rt   (rt),
        .rd   (rd),
        .imm  (imm),
        .word (word)
    );

    assign accept = in_valid && in_ready;
    assign at_top = (ptr == PTR_MAX);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (last || at_top)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= accept;
            if (state == S_IDLE && start) begin
                ptr      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end
            if (accept) begin
                mem_addr  <= ptr;
                mem_wdata <= word;
                count     <= count + 1'b1;
                // The pointer parks at the top word; leaving LOAD there is the overflow exit.
                if (!at_top) ptr <= ptr + 1'b1;
                if (at_top && !last) overflow <= 1'b1;
            end
        end
    end

endmodule
